// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 8-bit CPU: sequencer state encoding,
// halt instruction default, strobe bundle and opcode constants used by control_unit.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_REGREAD = 4'd3,
    ST_EXECUTE = 4'd4,
    ST_MEM     = 4'd5,
    ST_WBSEL   = 4'd6,
    ST_WB      = 4'd7,
    ST_PCUPD   = 4'd8,
    ST_HALT    = 4'd9
  } seq_state_e;

  localparam logic [7:0] HALT_INSTR_DEFAULT = 8'h00;

  // Opcode lives in instruction bits [7:5]
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_BNE = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic regread;
    logic execute;
    logic mem_req;
    logic wbsel;
    logic wb;
    logic pc;
    logic startup;
    logic halted;
  } strobe_t;

  function automatic logic is_halt(input logic [7:0] instr, input logic [7:0] halt_instr);
    return instr == halt_instr;
  endfunction

  function automatic logic [2:0] opcode_of(input logic [7:0] instr);
    return instr[7:5];
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// MEM-stage wait counter: held at zero while clr is high, counts up otherwise,
// and flags when the count equals the programmed limit.
module seq_timeout_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] limit,
  output logic       hit
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == limit);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multicycle control FSM for the 8-bit CPU: one-cycle stage enables on a single clock,
// start/halt, single-step, data-memory handshake with timeout and a retired counter.
module cpu_stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0]  HALT_INSTR  = HALT_INSTR_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          SKIP_NO_MEM = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             single_step,
  input  logic             step,
  input  logic [7:0]       instruction_data,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             reg_w_en,
  input  logic             mem_ack,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             regread_en,
  output logic             execute_en,
  output logic             mem_req,
  output logic             wbsel_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             startup,
  output logic             halted,
  output logic             mem_error,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  strobe_t          out_q, out_d;
  logic             mem_error_q, mem_error_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic mem_any;
  logic to_clr;
  logic to_hit;

  assign mem_any = mem_r_en | mem_w_en;
  assign to_clr  = (state_q != ST_MEM);

  seq_timeout_counter u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .limit (8'(MEM_TIMEOUT)),
    .hit   (to_hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_error_d = mem_error_q;
    first_d     = first_q;
    retired_d   = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (start || (step && single_step)) begin
          state_d = ST_FETCH;
          first_d = 1'b1;
        end
      end
      ST_FETCH:   state_d = is_halt(instruction_data, HALT_INSTR) ? ST_HALT : ST_DECODE;
      ST_DECODE:  state_d = ST_REGREAD;
      ST_REGREAD: state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (mem_any || !SKIP_NO_MEM) ? ST_MEM : ST_WBSEL;
      ST_MEM: begin
        // An ack arriving on the final allowed cycle still completes the access
        if (!mem_any || mem_ack) begin
          state_d = ST_WBSEL;
        end else if (to_hit) begin
          state_d     = ST_HALT;
          mem_error_d = 1'b1;
        end
      end
      ST_WBSEL:   state_d = ST_WB;
      ST_WB:      state_d = ST_PCUPD;
      ST_PCUPD: begin
        retired_d = retired_q + CNT_W'(1);
        first_d   = 1'b0;
        state_d   = single_step ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          first_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered strobes line up with state_q
    out_d = '0;
    case (state_d)
      ST_FETCH:   out_d.fetch   = 1'b1;
      ST_DECODE:  out_d.decode  = 1'b1;
      ST_REGREAD: out_d.regread = 1'b1;
      ST_EXECUTE: out_d.execute = 1'b1;
      ST_MEM:     out_d.mem_req = mem_any;
      ST_WBSEL:   out_d.wbsel   = 1'b1;
      ST_WB:      out_d.wb      = reg_w_en;
      ST_PCUPD: begin
        out_d.pc      = 1'b1;
        out_d.startup = first_d;
      end
      ST_HALT:    out_d.halted  = 1'b1;
      default:    out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      mem_error_q <= 1'b0;
      first_q     <= 1'b1;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      mem_error_q <= mem_error_d;
      first_q     <= first_d;
      retired_q   <= retired_d;
    end
  end

  assign fetch_en   = out_q.fetch;
  assign decode_en  = out_q.decode;
  assign regread_en = out_q.regread;
  assign execute_en = out_q.execute;
  assign mem_req    = out_q.mem_req;
  assign wbsel_en   = out_q.wbsel;
  assign wb_en      = out_q.wb;
  assign pc_en      = out_q.pc;
  assign startup    = out_q.startup;
  assign halted     = out_q.halted;
  assign mem_error  = mem_error_q;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench: the driver pushes each instruction's expected stage trace,
// a negedge monitor rebuilds the trace from the strobes and compares.
module tb_cpu_stage_sequencer;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n, start, single_step, step;
  logic [7:0]  instruction_data;
  logic        mem_r_en, mem_w_en, reg_w_en, mem_ack;
  logic        fetch_en, decode_en, regread_en, execute_en, mem_req;
  logic        wbsel_en, wb_en, pc_en, startup, halted, mem_error;
  logic [3:0]  state_o;
  logic [15:0] retired;

  cpu_stage_sequencer #(
    .HALT_INSTR  (8'h00),
    .MEM_TIMEOUT (TMO),
    .SKIP_NO_MEM (1'b1),
    .CNT_W       (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .single_step      (single_step),
    .step             (step),
    .instruction_data (instruction_data),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .reg_w_en         (reg_w_en),
    .mem_ack          (mem_ack),
    .fetch_en         (fetch_en),
    .decode_en        (decode_en),
    .regread_en       (regread_en),
    .execute_en       (execute_en),
    .mem_req          (mem_req),
    .wbsel_en         (wbsel_en),
    .wb_en            (wb_en),
    .pc_en            (pc_en),
    .startup          (startup),
    .halted           (halted),
    .mem_error        (mem_error),
    .state_o          (state_o),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  string q_tr[$];
  bit    q_su[$];
  int    q_ret[$];
  bit    q_err[$];
  int    q_gap[$];

  int ack_delay = 0;

  int m_cnt;
  bit m_first, m_err, need_launch, from_halt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Letters: F D R X fetch..execute, M mem wait, S wbsel, W/w writeback with/without write, P pc, H halt
  function automatic string exp_trace(input logic [7:0] ins, input bit mr, input bit mw,
                                      input bit rw, input int d);
    string s;
    if (ins == 8'h00) return "FH";
    s = "FDRX";
    if (mr || mw) begin
      if (d == 0 || d > TMO + 1) begin
        for (int i = 0; i < TMO + 1; i++) s = {s, "M"};
        return {s, "H"};
      end
      for (int i = 0; i < d; i++) s = {s, "M"};
    end
    s = {s, "S"};
    s = rw ? {s, "W"} : {s, "w"};
    return {s, "P"};
  endfunction

  // Data memory model: ack on the d-th cycle of a request, random noise when idle
  initial begin
    int mcnt;
    mcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt = 0;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        mcnt++;
        mem_ack = (ack_delay != 0) && (mcnt == ack_delay);
      end else begin
        mcnt = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  string m_cur = "";
  bit    m_active = 1'b0;
  bit    m_prev_h = 1'b0;
  int    m_gap = 0;
  int    m_obs_gap = 0;

  always @(negedge clk) begin
    int n;
    string ltr;
    if (!rst_n) begin
      m_active = 1'b0;
      m_cur    = "";
      m_gap    = 0;
      m_prev_h = 1'b0;
    end else begin
      n = int'(fetch_en) + int'(decode_en) + int'(regread_en) + int'(execute_en)
        + int'(mem_req) + int'(wbsel_en) + int'(wb_en) + int'(pc_en);
      ltr = "";
      if (n > 1 || (startup && !pc_en) || (halted && n != 0)) ltr = "?";
      else if (fetch_en)   ltr = "F";
      else if (decode_en)  ltr = "D";
      else if (regread_en) ltr = "R";
      else if (execute_en) ltr = "X";
      else if (mem_req)    ltr = "M";
      else if (wbsel_en)   ltr = "S";
      else if (wb_en)      ltr = "W";
      else if (pc_en)      ltr = "P";
      else if (state_o == 4'd5) ltr = "m";
      else if (state_o == 4'd7) ltr = "w";
      else if (halted && !m_prev_h) ltr = "H";

      if (fetch_en && !m_active) begin
        m_active  = 1'b1;
        m_cur     = "";
        m_obs_gap = m_gap;
      end

      if (m_active) begin
        m_cur = {m_cur, ltr};
      end else if (ltr != "" && !(halted && ltr == "H")) begin
        tests++;
        fails++;
        $display("FAIL stray_strobe: got %s expected no activity", ltr);
      end else if (!halted) begin
        m_gap++;
      end

      if (m_active && (pc_en || (halted && !m_prev_h))) begin
        if (q_tr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got %s expected none", m_cur);
        end else begin
          string et;
          bit    esu, eerr;
          int    eret, egap;
          et   = q_tr.pop_front();
          esu  = q_su.pop_front();
          eret = q_ret.pop_front();
          eerr = q_err.pop_front();
          egap = q_gap.pop_front();
          chk_s("trace", m_cur, et);
          chk("startup", startup, esu);
          chk("retired", retired, eret);
          chk("mem_error", mem_error, eerr);
          if (egap >= 0) chk("issue_gap", m_obs_gap, egap);
        end
        m_active = 1'b0;
        m_gap    = 0;
      end
      m_prev_h = halted;
    end
  end

  task automatic do_instr(input logic [7:0] ins, input bit mr, input bit mw, input bit rw,
                          input int d, input bit ss_after, input bit abort);
    bit tmo, first, done;
    instruction_data = ins;
    mem_r_en  = mr;
    mem_w_en  = mw;
    reg_w_en  = rw;
    ack_delay = d;
    tmo   = (ins != 8'h00) && (mr || mw) && (d == 0 || d > TMO + 1);
    first = need_launch ? 1'b1 : m_first;
    if (!abort) begin
      q_tr.push_back(exp_trace(ins, mr, mw, rw, d));
      q_su.push_back(first && ins != 8'h00 && !tmo);
      q_ret.push_back(m_cnt);
      q_err.push_back(m_err | tmo);
      q_gap.push_back(need_launch ? -1 : 0);
    end
    if (need_launch) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if (!from_halt && single_step) step = 1'b1;
      else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      step  = 1'b0;
      chk("launch_fetch_en", fetch_en, 1);
      chk("launch_state", state_o, 1);
    end else begin
      @(negedge clk);
    end
    m_first = first;
    single_step = ss_after;

    if (abort) begin
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
        if (state_o == 4'd4) done = 1'b1;
        else @(negedge clk);
      end
      chk("abort_in_execute", done, 1);
      chk("mem_error_before_reset", mem_error, m_err);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs",
             {fetch_en, decode_en, regread_en, execute_en, mem_req, wbsel_en, wb_en,
              pc_en, startup, halted, mem_error, state_o, retired}, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_abort_state", state_o, 0);
      chk("post_abort_retired", retired, 0);
      chk("post_abort_mem_error", mem_error, 0);
      m_cnt = 0;
      m_err = 1'b0;
      m_first = 1'b1;
      need_launch = 1'b1;
      from_halt = 1'b0;
      return;
    end

    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (pc_en || halted) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL completion_timeout: got no pc_en/halted expected completion of %0h", ins);
      need_launch = 1'b1;
      from_halt = 1'b1;
    end else if (pc_en) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_first = 1'b0;
      need_launch = ss_after;
      from_halt = 1'b0;
    end else begin
      m_err = m_err | tmo;
      need_launch = 1'b1;
      from_halt = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] ins;
    int r, d;
    rst_n = 1'b0;
    start = 1'b0;
    step = 1'b0;
    single_step = 1'b0;
    instruction_data = 8'h00;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    reg_w_en = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    m_first = 1'b1;
    need_launch = 1'b1;
    from_halt = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {fetch_en, decode_en, regread_en, execute_en, mem_req, wbsel_en, wb_en,
         pc_en, startup, halted, mem_error, state_o, retired}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", state_o, 0);
    chk("retired_after_reset", retired, 0);

    // Plain ALU loop, then lw with late ack, sw timeout, halt fetch
    repeat (3) do_instr(8'h41, 0, 0, 0, 0, 0, 0);
    do_instr(8'hA4, 1, 0, 1, 3, 0, 0);
    do_instr(8'hC5, 0, 1, 0, 0, 0, 0);
    do_instr(8'h00, 0, 0, 0, 0, 0, 0);

    // Single-step: one instruction per launch, then resume free running
    do_instr(8'h41, 0, 0, 1, 0, 1, 0);
    do_instr(8'h22, 0, 0, 1, 0, 1, 0);
    do_instr(8'h63, 1, 0, 1, TMO + 1, 0, 0);
    do_instr(8'h85, 0, 1, 0, 1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      ins = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      r = $urandom_range(0, 9);
      d = (r == 0) ? 0 : (r == 1) ? TMO + 1 : (r == 2) ? 1 : $urandom_range(1, TMO + 1);
      do_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), d, ($urandom_range(0, 4) == 0), 0);
    end

    // Reset in EXECUTE after a sticky error has been recorded
    do_instr(8'hC5, 0, 1, 0, 0, 0, 0);
    do_instr(8'hA4, 1, 0, 1, 3, 0, 1);
    do_instr(8'h41, 0, 0, 1, 0, 0, 0);
    do_instr(8'hA4, 1, 0, 1, 2, 0, 0);
    do_instr(8'h00, 0, 0, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q_tr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
